// File: rtl/clk_period_monitor.sv
// clk_period_monitor
//   Multi-channel clock/strobe period checker. Each mon_in bit is synchronised
//   into clk, rising edges are detected, and the number of clk cycles between
//   successive rising edges is measured. Each measurement is checked against
//   [cfg_min_period, cfg_max_period]. The block raises per-channel one-cycle
//   error pulses and a sticky error flag.
//
//   Parameters:
//     NUM_CH       number of monitored inputs (1..32)
//     CNT_W        width of the period counter and of the bounds
//     SYNC_STAGES  synchroniser flops per input (>=2)
//
//   Ports:
//     clk, rst_n       reference clock, async active-low reset
//     enable           global enable; low forces every channel idle
//     clear            sync clear of sticky flags, stats, meas_period and FSMs
//     mon_in           monitored inputs (asynchronous to clk)
//     cfg_min_period   shortest legal period (0 disables the short check)
//     cfg_max_period   longest legal period (all-ones disables long/timeout)
//     meas_valid       pulse per completed measurement
//     meas_period      last measured period, channel k at [k*CNT_W +: CNT_W]
//     err_short        pulse: measured < cfg_min_period
//     err_long         pulse: measured > cfg_max_period, or timeout
//     err_sticky       OR of all error pulses since reset/clear
//
//   Optional build macro CLK_MON_STATS_EN adds:
//     pass_cnt, fail_cnt  per-channel 16-bit saturating counters of in-window
//                         measurements and of error pulses (NUM_CH*16 bits)

module clk_period_monitor #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    clear,
   input  logic [NUM_CH-1:0]       mon_in,
   input  logic [CNT_W-1:0]        cfg_min_period,
   input  logic [CNT_W-1:0]        cfg_max_period,
   output logic [NUM_CH-1:0]       meas_valid,
   output logic [NUM_CH*CNT_W-1:0] meas_period,
   output logic [NUM_CH-1:0]       err_short,
   output logic [NUM_CH-1:0]       err_long,
   output logic [NUM_CH-1:0]       err_sticky
`ifdef CLK_MON_STATS_EN
   ,
   output logic [NUM_CH*16-1:0]    pass_cnt,
   output logic [NUM_CH*16-1:0]    fail_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_TIMEOUT
   } state_t;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_r;
      logic                   sync_qq;
      logic                   rise;
      state_t                 state_r;
      logic [CNT_W-1:0]       cnt_r;
      logic [CNT_W-1:0]       cnt_inc;
      logic [CNT_W-1:0]       period_r;
      logic                   valid_r;
      logic                   short_r;
      logic                   long_r;
      logic                   sticky_r;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_r  <= '0;
            sync_qq <= 1'b0;
         end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], mon_in[k]};
            sync_qq <= sync_r[SYNC_STAGES-1];
         end
      end

      assign rise    = sync_r[SYNC_STAGES-1] & ~sync_qq;
      assign cnt_inc = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);

`ifdef CLK_MON_STATS_EN
      logic [15:0] pass_r;
      logic [15:0] fail_r;
`endif

      // cnt_r holds the number of clk cycles since the last detect cycle, so
      // it restarts at 1 and equals the period when the next edge is seen.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            period_r <= '0;
            valid_r  <= 1'b0;
            short_r  <= 1'b0;
            long_r   <= 1'b0;
            sticky_r <= 1'b0;
`ifdef CLK_MON_STATS_EN
            pass_r   <= '0;
            fail_r   <= '0;
`endif
         end else begin
            valid_r  <= 1'b0;
            short_r  <= 1'b0;
            long_r   <= 1'b0;
            sticky_r <= sticky_r | short_r | long_r;
            if (clear) begin
               state_r  <= ST_IDLE;
               cnt_r    <= '0;
               period_r <= '0;
               sticky_r <= 1'b0;
`ifdef CLK_MON_STATS_EN
               pass_r   <= '0;
               fail_r   <= '0;
`endif
            end else if (!enable) begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
            end else begin
               case (state_r)
                  ST_IDLE: begin
                     if (rise) begin
                        state_r <= ST_ARMED;
                        cnt_r   <= CNT_W'(1);
                     end
                  end
                  ST_ARMED: begin
                     if (rise) begin
                        valid_r  <= 1'b1;
                        period_r <= cnt_r;
                        short_r  <= (cnt_r < cfg_min_period);
                        long_r   <= (cnt_r > cfg_max_period);
                        cnt_r    <= CNT_W'(1);
`ifdef CLK_MON_STATS_EN
                        if ((cnt_r < cfg_min_period) || (cnt_r > cfg_max_period))
                           fail_r <= (&fail_r) ? fail_r : fail_r + 16'd1;
                        else
                           pass_r <= (&pass_r) ? pass_r : pass_r + 16'd1;
`endif
                     end else if (cnt_r > cfg_max_period) begin
                        long_r  <= 1'b1;
                        state_r <= ST_TIMEOUT;
                        cnt_r   <= cnt_inc;
`ifdef CLK_MON_STATS_EN
                        fail_r  <= (&fail_r) ? fail_r : fail_r + 16'd1;
`endif
                     end else begin
                        cnt_r <= cnt_inc;
                     end
                  end
                  ST_TIMEOUT: begin
                     // The interval that timed out is discarded; the edge only restarts.
                     if (rise) begin
                        state_r <= ST_ARMED;
                        cnt_r   <= CNT_W'(1);
                     end else begin
                        cnt_r <= cnt_inc;
                     end
                  end
                  default: begin
                     state_r <= ST_IDLE;
                     cnt_r   <= '0;
                  end
               endcase
            end
         end
      end

      assign meas_valid[k]                  = valid_r;
      assign meas_period[k*CNT_W +: CNT_W]  = period_r;
      assign err_short[k]                   = short_r;
      assign err_long[k]                    = long_r;
      assign err_sticky[k]                  = sticky_r;
`ifdef CLK_MON_STATS_EN
      assign pass_cnt[k*16 +: 16]           = pass_r;
      assign fail_cnt[k*16 +: 16]           = fail_r;
`endif
   end

endmodule
